wb_slave_mem: RTL

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

---
 rtl/wb_slave_mem_pkg.sv | 20 ++
 rtl/wb_slave_mem_ram.sv | 30 +++
 rtl/wb_slave_mem.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mem_pkg.sv
// Shared types for the Wishbone slave memory model: response modes and FSM states.
package wb_slave_mem_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ACK  = 2'd1,
    ERR  = 2'd2,
    RTY  = 2'd3
  } resp_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2
  } state_t;

  localparam int RETRY_WIDTH = 8;
  localparam int XFER_WIDTH  = 16;

endpackage

// File: rtl/wb_slave_mem_ram.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module wb_slave_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int MEM_AW     = $clog2(DEPTH),
  parameter int NUM_LANES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MEM_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Combinational read so data is ready on the same edge the FSM enters TERM.
  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a byte-lane RAM, with configurable wait states
// and response mode (ACK/ERR/RTY/none) for exercising bus masters.
module wb_slave_mem
  import wb_slave_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]     m_wb_adr_o,
  input  logic [DATA_WIDTH-1:0]     m_wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]   m_wb_sel_o,
  input  logic                      m_wb_we_o,
  input  logic                      m_wb_cyc_o,
  input  logic                      m_wb_stb_o,
  output logic [DATA_WIDTH-1:0]     m_wb_dat_i,
  output logic                      m_wb_ack_i,
  output logic                      m_wb_err_i,
  output logic                      m_wb_rty_i,
  input  logic [1:0]                cfg_resp,
  input  logic [3:0]                cfg_wait,
  input  logic [7:0]                cfg_max_retry,
  output logic [XFER_WIDTH-1:0]     xfer_cnt
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int MEM_AW    = $clog2(DEPTH);

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic [RETRY_WIDTH-1:0] retry_cnt;

  logic [MEM_AW-1:0]      lat_idx;
  logic                   lat_oor;
  logic [DATA_WIDTH-1:0]  lat_dat;
  logic [NUM_LANES-1:0]   lat_sel;
  logic                   lat_we;
  resp_mode_t             lat_resp;
  logic [7:0]             lat_max;

  logic [ADDR_WIDTH-1:0]  live_off;
  logic [ADDR_WIDTH-1:0]  live_word;
  logic                   live_oor;
  logic                   req;

  logic [MEM_AW-1:0]      cur_idx;
  logic                   cur_oor;
  logic                   cur_we;
  resp_mode_t             cur_resp;
  logic [7:0]             cur_max;

  logic                   go_term;
  logic                   term_ack;
  logic                   term_err;
  logic                   term_rty;
  logic                   ram_we;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign req       = m_wb_cyc_o && m_wb_stb_o;
  assign live_off  = m_wb_adr_o - BASE_ADDR;
  assign live_word = live_off >> LANE_BITS;
  assign live_oor  = (m_wb_adr_o < BASE_ADDR) || (live_word >= ADDR_WIDTH'(DEPTH));

  // With zero wait states the termination is decided on the request edge itself,
  // so the decision logic looks at the live bus in IDLE and the latched copy otherwise.
  always_comb begin
    if (state == IDLE) begin
      cur_idx  = live_word[MEM_AW-1:0];
      cur_oor  = live_oor;
      cur_we   = m_wb_we_o;
      cur_resp = resp_mode_t'(cfg_resp);
      cur_max  = cfg_max_retry;
    end else begin
      cur_idx  = lat_idx;
      cur_oor  = lat_oor;
      cur_we   = lat_we;
      cur_resp = lat_resp;
      cur_max  = lat_max;
    end
  end

  always_comb begin
    term_ack = 1'b0;
    term_err = 1'b0;
    term_rty = 1'b0;
    go_term  = 1'b0;
    if (cur_resp != NONE) begin
      if (cur_oor || cur_resp == ERR)                  term_err = 1'b1;
      else if (cur_resp == RTY && retry_cnt < cur_max) term_rty = 1'b1;
      else                                             term_ack = 1'b1;

      if (state == IDLE)      go_term = req && (cfg_wait == 4'd0);
      else if (state == WAIT) go_term = req && (wait_cnt <= 4'd1);
    end
  end

  // Writes land on the edge that closes an ACKed TERM cycle; a reset on that edge cancels it.
  assign ram_we = (state == TERM) && m_wb_ack_i && lat_we && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      retry_cnt  <= '0;
      xfer_cnt   <= '0;
      m_wb_ack_i <= 1'b0;
      m_wb_err_i <= 1'b0;
      m_wb_rty_i <= 1'b0;
      m_wb_dat_i <= '0;
      lat_idx    <= '0;
      lat_oor    <= 1'b0;
      lat_dat    <= '0;
      lat_sel    <= '0;
      lat_we     <= 1'b0;
      lat_resp   <= NONE;
      lat_max    <= '0;
    end else begin
      m_wb_ack_i <= 1'b0;
      m_wb_err_i <= 1'b0;
      m_wb_rty_i <= 1'b0;
      m_wb_dat_i <= '0;

      case (state)
        IDLE: begin
          if (req) begin
            lat_idx  <= live_word[MEM_AW-1:0];
            lat_oor  <= live_oor;
            lat_dat  <= m_wb_dat_o;
            lat_sel  <= m_wb_sel_o;
            lat_we   <= m_wb_we_o;
            lat_resp <= resp_mode_t'(cfg_resp);
            lat_max  <= cfg_max_retry;
            wait_cnt <= cfg_wait;
            state    <= go_term ? TERM : WAIT;
          end
        end
        WAIT: begin
          if (!req)                   state    <= IDLE;
          else if (go_term)           state    <= TERM;
          else if (wait_cnt > 4'd1)   wait_cnt <= wait_cnt - 4'd1;
        end
        TERM:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (go_term) begin
        m_wb_ack_i <= term_ack;
        m_wb_err_i <= term_err;
        m_wb_rty_i <= term_rty;
        if (term_ack) begin
          xfer_cnt  <= xfer_cnt + 16'd1;
          retry_cnt <= '0;
          if (!cur_we) m_wb_dat_i <= ram_rdata;
        end else if (term_err) begin
          retry_cnt <= '0;
        end else if (retry_cnt != 8'hFF) begin
          retry_cnt <= retry_cnt + 8'd1;
        end
      end
    end
  end

  wb_slave_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (ram_we),
    .be   (lat_sel),
    .waddr(lat_idx),
    .wdata(lat_dat),
    .raddr(cur_idx),
    .rdata(ram_rdata)
  );

endmodule
